// File: rtl/dmem_read_arbiter.sv
// rtl/dmem_read_arbiter.sv - two-port read arbiter for the shared data/constant memory
// Port 1 has priority; port 0 wins contention after MAX_WAIT consecutive denials.
module dmem_read_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_size,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_size,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [3:0] wait0_q, wait0_d;
  logic       issue_vld_q, issue_vld_d;
  logic       owner_q, owner_d;
  logic       oor_q, oor_d;
  logic       starved;
  logic       grant0, grant1;

  always_comb begin
    starved = (wait0_q == 4'(MAX_WAIT));
    // Grants are gated by rst_n so nothing handshakes while reset is held.
    grant0  = rst_n && req0_valid && (!req1_valid || starved);
    grant1  = rst_n && req1_valid && !(req0_valid && starved);

    mem_addr = '0;
    mem_size = '0;
    if (grant0) begin
      mem_addr = req0_addr;
      mem_size = req0_size;
    end else if (grant1) begin
      mem_addr = req1_addr;
      mem_size = req1_size;
    end

    wait0_d = '0;
    if (req0_valid && !grant0) begin
      wait0_d = starved ? wait0_q : wait0_q + 4'd1;
    end

    issue_vld_d = grant0 || grant1;
    owner_d     = owner_q;
    oor_d       = oor_q;
    if (issue_vld_d) begin
      owner_d = grant1;
      oor_d   = (mem_addr >= ADDR_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait0_q     <= '0;
      issue_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      wait0_q     <= wait0_d;
      issue_vld_q <= issue_vld_d;
      owner_q     <= owner_d;
      oor_q       <= oor_d;
    end
  end

  // Out-of-range reads still return through the owner's port, with the memory word discarded.
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = issue_vld_q && !owner_q;
  assign rsp1_valid = issue_vld_q && owner_q;
  assign rsp0_data  = (rsp0_valid && !oor_q) ? mem_rdata : '0;
  assign rsp1_data  = (rsp1_valid && !oor_q) ? mem_rdata : '0;
  assign rsp0_err   = rsp0_valid && oor_q;
  assign rsp1_err   = rsp1_valid && oor_q;
  assign busy       = issue_vld_q;

endmodule
